// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory controller: access modes,
// FSM states, access size decode and RISC-V load extension.
package mem_pkg;

    localparam int DWORD_BITS = 64;
    localparam int BYTE_BITS  = 8;

    // funct3 encoding of the MEM-stage access
    typedef enum logic [2:0] {
        MODE_B   = 3'b000,
        MODE_H   = 3'b001,
        MODE_W   = 3'b010,
        MODE_D   = 3'b011,
        MODE_BU  = 3'b100,
        MODE_HU  = 3'b101,
        MODE_WU  = 3'b110,
        MODE_ILL = 3'b111
    } mem_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS0 = 2'd1,
        ST_ACCESS1 = 2'd2,
        ST_RESP    = 2'd3
    } mem_state_e;

    // Access size in bytes, taken from mode[1:0]
    function automatic logic [3:0] size_of(input logic [2:0] mode);
        logic [3:0] s;
        case (mode[1:0])
            2'b00:   s = 4'd1;
            2'b01:   s = 4'd2;
            2'b10:   s = 4'd4;
            default: s = 4'd8;
        endcase
        return s;
    endfunction

    // One bit per byte touched by the access, LSB-aligned
    function automatic logic [7:0] byte_mask(input logic [2:0] mode);
        logic [7:0] m;
        case (mode[1:0])
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Truncate to the access size and extend: sign when mode[2]=0, zero otherwise
    function automatic logic [DWORD_BITS-1:0] load_extend(input logic [DWORD_BITS-1:0] raw,
                                                          input logic [2:0] mode);
        logic [DWORD_BITS-1:0] r;
        logic sext;
        sext = ~mode[2];
        case (mode[1:0])
            2'b00:   r = {{56{sext & raw[7]}},  raw[7:0]};
            2'b01:   r = {{48{sext & raw[15]}}, raw[15:0]};
            2'b10:   r = {{32{sext & raw[31]}}, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_line_ram.sv
// Line-organised storage: one write port with per-byte enables and one
// registered read port. A read of the line being written returns old data.
module mem_line_ram
    import mem_pkg::*;
#(
    parameter int LINE_BYTES = 8,
    parameter int IDX_BITS   = 21
) (
    input  logic                             clk,
    input  logic                             rd_en,
    input  logic [IDX_BITS-1:0]              rd_line,
    output logic [LINE_BYTES*BYTE_BITS-1:0]  rd_data,
    input  logic [LINE_BYTES-1:0]            wr_be,
    input  logic [IDX_BITS-1:0]              wr_line,
    input  logic [LINE_BYTES*BYTE_BITS-1:0]  wr_data
);

    localparam int LINES     = 1 << IDX_BITS;
    localparam int LINE_BITS = LINE_BYTES * BYTE_BITS;

    logic [LINE_BITS-1:0] mem_q [LINES];
    logic [LINE_BITS-1:0] rd_data_q;

    // Byte-enabled write and registered read; the read samples pre-write contents
    always_ff @(posedge clk) begin
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (wr_be[b]) begin
                mem_q[wr_line][b*BYTE_BITS +: BYTE_BITS] <= wr_data[b*BYTE_BITS +: BYTE_BITS];
            end
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_line];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked MEM-stage data-memory controller. Splits line-crossing accesses
// into two line operations and returns one registered, extended response
// per request. Erroring requests skip storage entirely.
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_BITS  = 24,
    parameter int LINE_BYTES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [63:0]           req_addr,
    input  logic [2:0]            req_mode,
    input  logic [DWORD_BITS-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DWORD_BITS-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int OFF_BITS   = $clog2(LINE_BYTES);
    localparam int IDX_BITS   = ADDR_BITS - OFF_BITS;
    localparam int LINE_BITS  = LINE_BYTES * BYTE_BITS;
    localparam int WIDE_BYTES = 2 * LINE_BYTES;
    localparam int WIDE_BITS  = WIDE_BYTES * BYTE_BITS;
    localparam logic [ADDR_BITS:0] ADDR_LIMIT = {1'b1, {ADDR_BITS{1'b0}}};

    // Request decode, evaluated on the live inputs at accept
    logic [3:0]           req_size;
    logic [ADDR_BITS:0]   req_end;
    logic                 req_err;
    logic                 req_cross;

    // Captured request
    mem_state_e            state_q;
    logic                  req_ready_q;
    logic [IDX_BITS-1:0]   line_q;
    logic [OFF_BITS-1:0]   off_q;
    logic                  we_q;
    logic [2:0]            mode_q;
    logic [DWORD_BITS-1:0] wdata_q;
    logic                  cross_q;
    logic [LINE_BITS-1:0]  line0_q;

    // Response registers
    logic                  resp_valid_q;
    logic [DWORD_BITS-1:0] resp_rdata_q;
    logic                  resp_err_q;

    // Lane / shift datapath
    logic [WIDE_BYTES-1:0] lane_mask;
    logic [WIDE_BITS-1:0]  wdata_wide;
    logic [WIDE_BITS-1:0]  rd_wide;
    logic [WIDE_BITS-1:0]  rd_shift;
    logic [DWORD_BITS-1:0] load_value;

    // Storage port signals
    logic                  ram_rd_en;
    logic [IDX_BITS-1:0]   ram_rd_line;
    logic [LINE_BITS-1:0]  ram_rd_data;
    logic [LINE_BYTES-1:0] ram_wr_be;
    logic [IDX_BITS-1:0]   ram_wr_line;
    logic [LINE_BITS-1:0]  ram_wr_data;

    assign req_size  = size_of(req_mode);
    assign req_end   = {1'b0, req_addr[ADDR_BITS-1:0]} + {{(ADDR_BITS-3){1'b0}}, req_size};
    assign req_err   = (req_mode == MODE_ILL)
                     || (req_we && req_mode[2])
                     || (req_addr[63:ADDR_BITS] != '0)
                     || (req_end > ADDR_LIMIT);
    assign req_cross = (int'(req_addr[OFF_BITS-1:0]) + int'(req_size)) > LINE_BYTES;

    // Store data and byte lanes placed across two consecutive lines
    assign lane_mask  = {{(WIDE_BYTES-8){1'b0}}, byte_mask(mode_q)} << off_q;
    assign wdata_wide = {{(WIDE_BITS-DWORD_BITS){1'b0}}, wdata_q} << {off_q, 3'b000};

    // Load assembly: in ACCESS1 the RAM holds the upper line and line0_q the lower
    always_comb begin
        rd_wide = {{LINE_BITS{1'b0}}, ram_rd_data};
        if (state_q == ST_ACCESS1) begin
            rd_wide = {ram_rd_data, line0_q};
        end
        rd_shift   = rd_wide >> {off_q, 3'b000};
        load_value = load_extend(rd_shift[DWORD_BITS-1:0], mode_q);
    end

    // Storage control: read is issued one state ahead so data lands on the access edge
    always_comb begin
        ram_rd_en   = 1'b0;
        ram_rd_line = line_q;
        ram_wr_be   = '0;
        ram_wr_line = line_q;
        ram_wr_data = wdata_wide[LINE_BITS-1:0];
        case (state_q)
            ST_IDLE: begin
                ram_rd_en   = req_valid && !req_err;
                ram_rd_line = req_addr[ADDR_BITS-1:OFF_BITS];
            end
            ST_ACCESS0: begin
                ram_rd_en   = cross_q;
                ram_rd_line = line_q + IDX_BITS'(1);
                if (we_q) begin
                    ram_wr_be = lane_mask[LINE_BYTES-1:0];
                end
            end
            ST_ACCESS1: begin
                ram_wr_line = line_q + IDX_BITS'(1);
                ram_wr_data = wdata_wide[WIDE_BITS-1:LINE_BITS];
                if (we_q) begin
                    ram_wr_be = lane_mask[WIDE_BYTES-1:LINE_BYTES];
                end
            end
            default: ;
        endcase
    end

    mem_line_ram #(
        .LINE_BYTES (LINE_BYTES),
        .IDX_BITS   (IDX_BITS)
    ) u_ram (
        .clk     (clk),
        .rd_en   (ram_rd_en),
        .rd_line (ram_rd_line),
        .rd_data (ram_rd_data),
        .wr_be   (ram_wr_be),
        .wr_line (ram_wr_line),
        .wr_data (ram_wr_data)
    );

    // Sequencer with request capture and registered handshake/response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            line_q       <= '0;
            off_q        <= '0;
            we_q         <= 1'b0;
            mode_q       <= '0;
            wdata_q      <= '0;
            cross_q      <= 1'b0;
            line0_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        line_q      <= req_addr[ADDR_BITS-1:OFF_BITS];
                        off_q       <= req_addr[OFF_BITS-1:0];
                        we_q        <= req_we;
                        mode_q      <= req_mode;
                        wdata_q     <= req_wdata;
                        cross_q     <= req_cross;
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q <= ST_ACCESS0;
                        end
                    end
                end
                ST_ACCESS0: begin
                    if (cross_q) begin
                        state_q <= ST_ACCESS1;
                        line0_q <= ram_rd_data;
                    end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_q ? '0 : load_value;
                    end
                end
                ST_ACCESS1: begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= we_q ? '0 : load_value;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: stores/loads, crossing accesses,
// error handling, response back-pressure and reset during a crossing store.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [63:0] req_addr = '0;
    logic [2:0]  req_mode = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .ADDR_BITS  (24),
        .LINE_BYTES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_mode   (req_mode),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete request/response transaction with optional response back-pressure
    task automatic do_req(input string tag, input logic we, input logic [63:0] addr,
                          input logic [2:0] mode, input logic [63:0] wdata,
                          input logic [63:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_mode  = mode;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        // Scramble the request fields; the captured values must be used
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = {$urandom, $urandom};
        req_mode  = 3'($urandom);
        req_wdata = {$urandom, $urandom};
        lat = 1;
        while (!resp_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        @(negedge clk);
        chk({tag, ".rdata"}, resp_rdata, exp_rdata);
        chk({tag, ".err"}, 64'(resp_err), 64'(exp_err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 64'(resp_valid), 64'(1));
            chk({tag, ".hold_rdata"}, resp_rdata, exp_rdata);
            chk({tag, ".hold_err"}, 64'(resp_err), 64'(exp_err));
            chk({tag, ".hold_ready"}, 64'(req_ready), 64'(0));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, ".done_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, ".done_ready"}, 64'(req_ready), 64'(1));
        $display("txn %-14s we=%0d addr=%h mode=%0d rdata=%h err=%0d lat=%0d",
                 tag, we, addr, mode, exp_rdata, exp_err, lat);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.req_ready", 64'(req_ready), 64'(1));
        chk("rst.resp_valid", 64'(resp_valid), 64'(0));
        chk("rst.resp_rdata", resp_rdata, 64'(0));
        chk("rst.resp_err", 64'(resp_err), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel.req_ready", 64'(req_ready), 64'(1));

        // Aligned doubleword
        do_req("sd_100", 1'b1, 64'h100, 3'b011, 64'h1122334455667788, 64'h0, 1'b0, 2, 0);
        do_req("ld_100", 1'b0, 64'h100, 3'b011, 64'h0, 64'h1122334455667788, 1'b0, 2, 0);

        // Byte store, sign/zero extended byte loads
        do_req("sd_200", 1'b1, 64'h200, 3'b011, 64'h0, 64'h0, 1'b0, 2, 0);
        do_req("sb_203", 1'b1, 64'h203, 3'b000, 64'hDEADBE80, 64'h0, 1'b0, 2, 0);
        do_req("ld_200", 1'b0, 64'h200, 3'b011, 64'h0, 64'h0000000080000000, 1'b0, 2, 0);
        do_req("lb_203", 1'b0, 64'h203, 3'b000, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0, 2, 0);
        do_req("lbu_203", 1'b0, 64'h203, 3'b100, 64'h0, 64'h80, 1'b0, 2, 0);

        // Line-crossing store and loads
        do_req("sd_305", 1'b1, 64'h305, 3'b011, 64'h0807060504030201, 64'h0, 1'b0, 3, 0);
        do_req("lwu_306", 1'b0, 64'h306, 3'b110, 64'h0, 64'h05040302, 1'b0, 3, 0);
        do_req("ld_305", 1'b0, 64'h305, 3'b011, 64'h0, 64'h0807060504030201, 1'b0, 3, 0);
        do_req("lh_307", 1'b0, 64'h307, 3'b001, 64'h0, 64'h0403, 1'b0, 3, 0);

        // Word sign vs zero extension
        do_req("sw_500", 1'b1, 64'h500, 3'b010, 64'hFFFF_FFFF_8765_4321, 64'h0, 1'b0, 2, 0);
        do_req("lw_500", 1'b0, 64'h500, 3'b010, 64'h0, 64'hFFFFFFFF87654321, 1'b0, 2, 0);
        do_req("lwu_500", 1'b0, 64'h500, 3'b110, 64'h0, 64'h87654321, 1'b0, 2, 0);
        do_req("lhu_502", 1'b0, 64'h502, 3'b101, 64'h0, 64'h8765, 1'b0, 2, 0);

        // Errors: illegal mode, unsigned-store mode, out-of-range addresses
        do_req("sd_000", 1'b1, 64'h0, 3'b011, 64'h5A5A5A5A5A5A5A5A, 64'h0, 1'b0, 2, 0);
        do_req("ill_mode", 1'b0, 64'h100, 3'b111, 64'h0, 64'h0, 1'b1, 1, 0);
        do_req("st_bu", 1'b1, 64'h0, 3'b100, 64'hFF, 64'h0, 1'b1, 1, 0);
        do_req("sd_hi_addr", 1'b1, 64'h1_0000_0000, 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1, 0);
        do_req("ld_000", 1'b0, 64'h0, 3'b011, 64'h0, 64'h5A5A5A5A5A5A5A5A, 1'b0, 2, 0);
        do_req("ld_top_ovf", 1'b0, 64'hFFFFFC, 3'b011, 64'h0, 64'h0, 1'b1, 1, 0);
        do_req("sw_top", 1'b1, 64'hFFFFFC, 3'b010, 64'h13579BDF, 64'h0, 1'b0, 2, 0);
        do_req("lw_top", 1'b0, 64'hFFFFFC, 3'b010, 64'h0, 64'h13579BDF, 1'b0, 2, 0);

        // Back-pressure on the response
        do_req("ld_hold", 1'b0, 64'h100, 3'b011, 64'h0, 64'h1122334455667788, 1'b0, 2, 5);

        // Reset during ACCESS1 of a crossing store
        do_req("sd_400", 1'b1, 64'h400, 3'b011, 64'h0, 64'h0, 1'b0, 2, 0);
        do_req("sd_408", 1'b1, 64'h408, 3'b011, 64'h0, 64'h0, 1'b0, 2, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 64'h405;
        req_mode  = 3'b011;
        req_wdata = 64'hAABBCCDDEEFF1122;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_mid.req_ready", 64'(req_ready), 64'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid.rel_ready", 64'(req_ready), 64'(1));
        $display("txn %-14s crossing SD @405 interrupted in ACCESS1", "rst_mid");
        do_req("ld_400", 1'b0, 64'h400, 3'b011, 64'h0, 64'hFF11220000000000, 1'b0, 2, 0);
        do_req("ld_408", 1'b0, 64'h408, 3'b011, 64'h0, 64'h0, 1'b0, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
